// File: rtl/ravenoc_pkg.sv
// Shared types and constants for the AXI read / virtual-channel bridge.
//   region_e   : decoded target of an AR request
//   st_e       : response FSM states
//   ot_entry_t : one outstanding-transaction record held in the OT queue
//   *_BASE_DEF : default address map bases; VC i lives at base + VC_STRIDE*i
package ravenoc_pkg;

  localparam logic [15:0] RD_BASE_DEF  = 16'h2000;
  localparam logic [15:0] CSR_BASE_DEF = 16'h3000;
  localparam int          VC_STRIDE    = 8;
  localparam int          ID_W_MAX     = 16;  // widest ARID the OT entry can carry
  localparam int          VC_IDX_W     = 3;   // enough for up to 8 VCs

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;

  typedef enum logic [1:0] {RG_DATA, RG_CSR, RG_ERR} region_e;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CSR, ST_ERR} st_e;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [7:0]          len;
    region_e             region;
    logic [VC_IDX_W-1:0] vc;
  } ot_entry_t;

  function automatic logic [15:0] vc_addr(input logic [15:0] base, input int i);
    return base + 16'(VC_STRIDE * i);
  endfunction

endpackage

// File: rtl/axi_rd_vc_if_if.sv
// Bundle of the AXI read channels, the flit push port and the per-VC empty
// flags. slave = the bridge, master = whoever drives AR/R-ready/flits.
interface axi_rd_vc_if_if #(
  parameter int N_VC   = 3,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int VC_W = (N_VC > 1) ? $clog2(N_VC) : 1;

  logic              arvalid;
  logic              arready;
  logic [15:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [VC_W-1:0]   pkt_vc;
  logic [DATA_W-1:0] pkt_data;

  logic [N_VC-1:0]   vc_empty;

  modport slave (
    input  arvalid, araddr, arlen, arsize, arid,
    output arready,
    input  rready,
    output rvalid, rdata, rresp, rlast, rid,
    input  pkt_valid, pkt_vc, pkt_data,
    output pkt_ready, vc_empty
  );

  modport master (
    output arvalid, araddr, arlen, arsize, arid,
    input  arready,
    output rready,
    input  rvalid, rdata, rresp, rlast, rid,
    output pkt_valid, pkt_vc, pkt_data,
    input  pkt_ready, vc_empty
  );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with show-ahead read data and an occupancy count.
//   clk_i/rst_i : clock, async active-high reset (pointers/count only)
//   wr_i/wdata_i: push; ignored when full
//   rd_i        : pop; ignored when empty
//   rdata_o     : current head entry
//   count_o     : number of stored entries (0..DEPTH)
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         rd_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_ok, rd_ok;

  assign wr_ok   = wr_i && (cnt_q != CW'(DEPTH));
  assign rd_ok   = rd_i && (cnt_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      if (wr_ok && !rd_ok)      cnt_q <= cnt_q + CW'(1);
      else if (rd_ok && !wr_ok) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/axi_rd_vc_if.sv
// AXI read slave in front of N_VC virtual-channel receive buffers.
// AR requests are decoded into DATA (pop flits of one VC), CSR (report one
// VC's occupancy) or ERR (SLVERR, zero data) and queued in an outstanding
// table; a response FSM serves the queue head one burst at a time.
//   aclk, arst : clock, async active-high reset
//   bus        : AR/R channels, flit push port, per-VC empty flags
module axi_rd_vc_if
  import ravenoc_pkg::*;
#(
  parameter int          N_VC      = 3,
  parameter int          DATA_W    = 32,
  parameter int          BUF_DEPTH = 4,
  parameter int          OT_DEPTH  = 2,
  parameter int          ID_W      = 4,
  parameter logic [15:0] RD_BASE   = RD_BASE_DEF,
  parameter logic [15:0] CSR_BASE  = CSR_BASE_DEF
) (
  input logic            aclk,
  input logic            arst,
  axi_rd_vc_if_if.slave  bus
);
  localparam int         CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int         OT_CW     = $clog2(OT_DEPTH + 1);
  localparam logic [2:0] SIZE_LOG2 = 3'($clog2(DATA_W / 8));

  ot_entry_t                    dec, ot_head;
  logic [OT_CW-1:0]             ot_cnt;
  logic                         ot_full, ot_empty, ar_hs;

  logic [N_VC-1:0][DATA_W-1:0]  vc_head;
  logic [N_VC-1:0][CNT_W-1:0]   vc_cnt;
  logic [N_VC-1:0]              vc_full, vc_push, vc_pop;
  logic                         pkt_rdy;

  logic [DATA_W-1:0]            sel_head;
  logic [CNT_W-1:0]             sel_cnt;
  logic                         sel_empty;

  st_e                          state_q, state_d;
  logic [7:0]                   beat_q, beat_d;
  logic [CNT_W-1:0]             csr_q, csr_d;

  logic                         rvalid, rlast, r_hs, burst_done;
  logic [DATA_W-1:0]            rdata;
  logic [1:0]                   rresp;

  // ---------------- AR decode / outstanding queue ----------------
  always_comb begin
    dec        = '0;
    dec.id     = ID_W_MAX'(bus.arid);
    dec.len    = bus.arlen;
    dec.region = RG_ERR;
    for (int i = 0; i < N_VC; i++) begin
      if (bus.araddr == vc_addr(RD_BASE, i)) begin
        dec.region = RG_DATA;
        dec.vc     = VC_IDX_W'(i);
      end
      if (bus.araddr == vc_addr(CSR_BASE, i)) begin
        dec.region = RG_CSR;
        dec.vc     = VC_IDX_W'(i);
      end
    end
    if (bus.arsize != SIZE_LOG2) dec.region = RG_ERR;
  end

  assign ot_full     = (ot_cnt == OT_CW'(OT_DEPTH));
  assign ot_empty    = (ot_cnt == '0);
  assign bus.arready = ~ot_full;
  assign ar_hs       = bus.arvalid && ~ot_full;

  fifo #(.WIDTH($bits(ot_entry_t)), .DEPTH(OT_DEPTH)) u_ot (
    .clk_i(aclk), .rst_i(arst),
    .wr_i(ar_hs), .wdata_i(dec),
    .rd_i(burst_done), .rdata_o(ot_head),
    .count_o(ot_cnt)
  );

  // ---------------- VC receive buffers ----------------
  // Out-of-range pkt_vc matches no buffer, so ready stays low.
  always_comb begin
    pkt_rdy = 1'b0;
    vc_push = '0;
    for (int i = 0; i < N_VC; i++) begin
      if (int'(bus.pkt_vc) == i) begin
        pkt_rdy    = ~vc_full[i];
        vc_push[i] = bus.pkt_valid && ~vc_full[i];
      end
    end
  end
  assign bus.pkt_ready = pkt_rdy;

  for (genvar g = 0; g < N_VC; g++) begin : g_vc
    fifo #(.WIDTH(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
      .clk_i(aclk), .rst_i(arst),
      .wr_i(vc_push[g]), .wdata_i(bus.pkt_data),
      .rd_i(vc_pop[g]), .rdata_o(vc_head[g]),
      .count_o(vc_cnt[g])
    );
    assign vc_full[g]      = (vc_cnt[g] == CNT_W'(BUF_DEPTH));
    assign bus.vc_empty[g] = (vc_cnt[g] == '0);
  end

  // VC addressed by the burst at the OT head.
  always_comb begin
    sel_head  = '0;
    sel_cnt   = '0;
    sel_empty = 1'b1;
    vc_pop    = '0;
    for (int i = 0; i < N_VC; i++) begin
      if (int'(ot_head.vc) == i) begin
        sel_head  = vc_head[i];
        sel_cnt   = vc_cnt[i];
        sel_empty = (vc_cnt[i] == '0);
        vc_pop[i] = (state_q == ST_DATA) && r_hs;
      end
    end
  end

  // ---------------- response FSM ----------------
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!ot_empty) begin
        case (ot_head.region)
          RG_DATA: state_d = ST_DATA;
          RG_CSR:  state_d = ST_CSR;
          default: state_d = ST_ERR;
        endcase
      end
      default: if (burst_done) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = RESP_OKAY;
    case (state_q)
      ST_DATA: begin
        rvalid = ~sel_empty;
        rdata  = sel_empty ? '0 : sel_head;
      end
      ST_CSR: begin
        rvalid = 1'b1;
        rdata  = DATA_W'(csr_q);
      end
      ST_ERR: begin
        rvalid = 1'b1;
        rresp  = RESP_SLVERR;
      end
      default: ;
    endcase
  end

  assign r_hs       = rvalid && bus.rready;
  assign rlast      = rvalid && (beat_q == ot_head.len);
  assign burst_done = r_hs && rlast;

  // Beat counter and CSR snapshot. The occupancy is latched when a CSR beat
  // is first presented so the value cannot move while the master stalls.
  always_comb begin
    beat_d = beat_q;
    if (state_q == ST_IDLE) beat_d = '0;
    else if (r_hs)          beat_d = beat_q + 8'd1;
    csr_d = csr_q;
    if ((state_q == ST_IDLE && state_d == ST_CSR) || (state_q == ST_CSR && r_hs))
      csr_d = sel_cnt;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      beat_q <= '0;
      csr_q  <= '0;
    end else begin
      beat_q <= beat_d;
      csr_q  <= csr_d;
    end
  end

  assign bus.rvalid = rvalid;
  assign bus.rdata  = rdata;
  assign bus.rresp  = rresp;
  assign bus.rlast  = rlast;
  assign bus.rid    = (state_q != ST_IDLE) ? ot_head.id[ID_W-1:0] : '0;
endmodule

// File: tb/tb_axi_rd_vc_if.sv
module tb_axi_rd_vc_if;
  logic aclk = 1'b0;
  logic arst = 1'b1;
  always #5 aclk = ~aclk;

  axi_rd_vc_if_if #(.N_VC(3), .DATA_W(32), .ID_W(4)) bus ();

  axi_rd_vc_if #(.N_VC(3), .DATA_W(32), .BUF_DEPTH(4), .OT_DEPTH(2), .ID_W(4)) dut (
    .aclk(aclk), .arst(arst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    int          pre_vc;
    int          pre_n;
    logic [31:0] pre_base;
    int          beats;
    logic [1:0]  resp;
    bit          inc;    // expected rdata = exp + beat index, else constant exp
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input int vc, input logic [31:0] d);
    bus.pkt_valid = 1'b1;
    bus.pkt_vc    = 2'(vc);
    bus.pkt_data  = d;
    @(negedge aclk);
    chk("pkt_ready", 32'(bus.pkt_ready), 32'd1);
    @(posedge aclk); #1;
    bus.pkt_valid = 1'b0;
  endtask

  task automatic ar(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                    input logic [3:0] id);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    bus.arlen   = l;
    bus.arsize  = s;
    bus.arid    = id;
    @(negedge aclk);
    chk("arready", 32'(bus.arready), 32'd1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  // Collects one burst with a periodic rready stall; checks every presented
  // beat (stalled beats included, which also covers output stability).
  task automatic collect(input int n, input logic [3:0] id, input logic [1:0] resp,
                         input bit inc, input logic [31:0] exp, input bit lat_chk);
    int cyc = 0;
    int k = 0;
    bit first = 1'b1;
    while (k < n && cyc < 300) begin
      bus.rready = (cyc % 3 != 1);
      @(negedge aclk);
      cyc++;
      if (bus.rvalid) begin
        if (first && lat_chk) chk("latency", cyc, 2);
        first = 1'b0;
        chk("rdata", bus.rdata, inc ? exp + 32'(k) : exp);
        chk("rresp", 32'(bus.rresp), 32'(resp));
        chk("rid",   32'(bus.rid), 32'(id));
        chk("rlast", 32'(bus.rlast), 32'(k == n - 1));
        if (bus.rready) k++;
      end
      @(posedge aclk); #1;
    end
    chk("beats", k, n);
    bus.rready = 1'b1;
    @(negedge aclk);
    chk("idle_gap", 32'(bus.rvalid), 32'd0);
    @(posedge aclk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_arready",   32'(bus.arready),   32'd1);
    chk("rst_rvalid",    32'(bus.rvalid),    32'd0);
    chk("rst_rlast",     32'(bus.rlast),     32'd0);
    chk("rst_rresp",     32'(bus.rresp),     32'd0);
    chk("rst_rdata",     bus.rdata,          32'd0);
    chk("rst_rid",       32'(bus.rid),       32'd0);
    chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
    chk("rst_vc_empty",  32'(bus.vc_empty),  32'h7);
  endtask

  initial begin
    //          addr      len   size  id     vc n  pre_base   beats resp  inc exp
    vecs[0]  = '{16'h2008, 8'd3, 3'd2, 4'h5, 1, 4, 32'h100, 4, 2'b00, 1'b1, 32'h100};
    vecs[1]  = '{16'h3010, 8'd0, 3'd2, 4'h3, 2, 3, 32'h0C0, 1, 2'b00, 1'b0, 32'd3};
    vecs[2]  = '{16'h2010, 8'd2, 3'd2, 4'h7, 0, 0, 32'h000, 3, 2'b00, 1'b1, 32'h0C0};
    vecs[3]  = '{16'h3010, 8'd1, 3'd2, 4'h4, 0, 0, 32'h000, 2, 2'b00, 1'b0, 32'd0};
    vecs[4]  = '{16'h4000, 8'd2, 3'd2, 4'h9, 0, 0, 32'h000, 3, 2'b10, 1'b0, 32'd0};
    vecs[5]  = '{16'h2000, 8'd0, 3'd3, 4'hA, 0, 1, 32'h055, 1, 2'b10, 1'b0, 32'd0};
    vecs[6]  = '{16'h2000, 8'd0, 3'd2, 4'h1, 0, 0, 32'h000, 1, 2'b00, 1'b1, 32'h055};
    vecs[7]  = '{16'h2018, 8'd0, 3'd2, 4'h2, 0, 0, 32'h000, 1, 2'b10, 1'b0, 32'd0};
    vecs[8]  = '{16'h2004, 8'd0, 3'd2, 4'h6, 0, 0, 32'h000, 1, 2'b10, 1'b0, 32'd0};
    vecs[9]  = '{16'h3000, 8'd0, 3'd2, 4'hB, 0, 2, 32'h010, 1, 2'b00, 1'b0, 32'd2};
    vecs[10] = '{16'h2000, 8'd1, 3'd2, 4'hC, 0, 0, 32'h000, 2, 2'b00, 1'b1, 32'h010};
    vecs[11] = '{16'h3008, 8'd0, 3'd2, 4'hF, 0, 0, 32'h000, 1, 2'b00, 1'b0, 32'd0};

    bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arid = '0;
    bus.rready = 0; bus.pkt_valid = 0; bus.pkt_vc = '0; bus.pkt_data = '0;

    // reset state
    @(negedge aclk);
    chk_reset_vals();
    @(negedge aclk);
    arst = 1'b0;
    @(posedge aclk); #1;

    // table-driven bursts
    for (int v = 0; v < 12; v++) begin
      for (int j = 0; j < vecs[v].pre_n; j++)
        push(vecs[v].pre_vc, vecs[v].pre_base + 32'(j));
      ar(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].id);
      collect(vecs[v].beats, vecs[v].id, vecs[v].resp, vecs[v].inc, vecs[v].exp, 1'b1);
    end

    // empty VC stalls the burst until flits arrive
    bus.rready = 1'b1;
    ar(16'h2000, 8'd1, 3'd2, 4'h3);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      chk("stall_rvalid", 32'(bus.rvalid), 32'd0);
      @(posedge aclk); #1;
    end
    bus.rready = 1'b0;
    push(0, 32'hA1);
    push(0, 32'hA2);
    collect(2, 4'h3, 2'b00, 1'b1, 32'hA1, 1'b0);

    // OT backpressure: third AR waits until the first burst drains
    begin
      int got = 0;
      bit acc = 1'b0;
      bus.rready = 1'b0;
      ar(16'h4000, 8'd0, 3'd2, 4'h1);
      ar(16'h4000, 8'd0, 3'd2, 4'h2);
      bus.arvalid = 1'b1; bus.araddr = 16'h4000; bus.arlen = 8'd0; bus.arid = 4'h3;
      @(negedge aclk);
      chk("ot_full_arready", 32'(bus.arready), 32'd0);
      @(posedge aclk); #1;
      bus.rready = 1'b1;
      for (int c = 0; c < 60 && got < 3; c++) begin
        @(negedge aclk);
        if (bus.arvalid && bus.arready) acc = 1'b1;
        if (bus.rvalid && bus.rready) begin
          chk("ot_rid",   32'(bus.rid),   32'(got + 1));
          chk("ot_rresp", 32'(bus.rresp), 32'h2);
          chk("ot_rlast", 32'(bus.rlast), 32'd1);
          got++;
        end
        @(posedge aclk); #1;
        if (acc) bus.arvalid = 1'b0;
      end
      chk("ot_bursts", got, 3);
      chk("ot_third_accepted", 32'(acc), 32'd1);
      bus.arvalid = 1'b0;
    end

    // full VC refuses flits; out-of-range VC refused; reset mid-burst
    for (int j = 0; j < 4; j++) push(0, 32'h200 + 32'(j));
    bus.pkt_valid = 1'b1; bus.pkt_vc = 2'd0; bus.pkt_data = 32'hDEAD;
    @(negedge aclk);
    chk("full_pkt_ready", 32'(bus.pkt_ready), 32'd0);
    chk("full_vc_empty0", 32'(bus.vc_empty[0]), 32'd0);
    bus.pkt_vc = 2'd3;
    #1;
    chk("badvc_pkt_ready", 32'(bus.pkt_ready), 32'd0);
    @(posedge aclk); #1;
    bus.pkt_valid = 1'b0; bus.pkt_vc = 2'd0;
    bus.rready = 1'b1;
    ar(16'h2000, 8'd3, 3'd2, 4'h2);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge aclk);
        if (bus.rvalid) begin
          seen = 1'b1;
          chk("mid_rdata", bus.rdata, 32'h200);
        end
        @(posedge aclk); #1;
      end
      chk("mid_seen", 32'(seen), 32'd1);
    end
    arst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge aclk);
    arst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    end
    chk("post_rst_vc_empty", 32'(bus.vc_empty), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
